// File: rtl/pa_stream_adapter_if.sv
// Handshake and data bundle for pa_stream_adapter: pass control, pixel input stream,
// per-pixel result stream and accumulated gradients.
interface pa_stream_adapter_if #(
  parameter int unsigned C_IN = 6,
  parameter int unsigned K    = 2,
  parameter int unsigned DW   = 32
);
  logic                   start;
  logic [K*C_IN*DW-1:0]   weights;
  logic [K*DW-1:0]        biases;
  logic                   in_valid;
  logic                   in_ready;
  logic [C_IN*DW-1:0]     x_in;
  logic [K*DW-1:0]        fmap_in;
  logic [K*DW-1:0]        err_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [K*DW-1:0]        z_out;
  logic [K*DW-1:0]        y_out;
  logic [K*DW-1:0]        err_out;
  logic [K*C_IN*DW-1:0]   dw_out;
  logic [K*DW-1:0]        db_out;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, weights, biases, in_valid, x_in, fmap_in, err_in, out_ready,
    output in_ready, out_valid, z_out, y_out, err_out, dw_out, db_out, busy, done
  );

  modport master (
    output start, weights, biases, in_valid, x_in, fmap_in, err_in, out_ready,
    input  in_ready, out_valid, z_out, y_out, err_out, dw_out, db_out, busy, done
  );
endinterface

// File: rtl/pa_stream_adapter.sv
// 1x1 conv parallel adapter (C_IN -> K) over a pixel stream using one shared FP32 mul and add.
// Define PA_BP_EN for backprop (err_out, weight/bias gradients); otherwise forward-only inference.
module pa_stream_adapter #(
  parameter int unsigned C_IN    = 6,
  parameter int unsigned K       = 2,
  parameter int unsigned NUM_PIX = 784,
  parameter int unsigned DW      = 32
) (
  input logic                clk,
  input logic                rst,
  pa_stream_adapter_if.slave bus
);

  localparam int unsigned CW = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_MAC, S_BIAS, S_RES,
`ifdef PA_BP_EN
    S_ERR, S_GRAD,
`endif
    S_OUT, S_DONE
  } state_t;

  // Single-precision multiply, round-to-nearest-even; subnormals flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic              g, st;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF && a[22:0] != '0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return b;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? FP_QNAN : {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      mr = mr >> 1; e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  // Single-precision add with guard/round/sticky, round-to-nearest-even; exact cancellation gives +0.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       big, sml;
    logic [7:0]        d;
    logic [26:0]       mb, ms, mask;
    logic [27:0]       sum;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic              s, found;
    logic signed [9:0] e;
    int unsigned       lz;
    if (a[30:23] == 8'hFF && a[22:0] != '0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return b;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return FP_QNAN;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    s  = big[31];
    e  = $signed({2'b00, big[30:23]});
    d  = big[30:23] - sml[30:23];
    mb = {1'b1, big[22:0], 3'b000};
    ms = {1'b1, sml[22:0], 3'b000};
    if (d >= 8'd27) begin
      ms = 27'd1;
    end else begin
      mask = ~(27'h7FF_FFFF << d);
      ms   = (ms >> d) | {26'd0, |(ms & mask)};
    end
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 10'sd1;
      end
    end else begin
      sum = {1'b0, mb} - {1'b0, ms};
      if (sum == '0) return 32'd0;
      lz = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < 27; i++) begin
        if (!found) begin
          if (sum[26 - i]) found = 1'b1;
          else lz++;
        end
      end
      sum = sum << lz;
      e   = e - $signed(10'(lz));
    end
    m  = sum[26:3];
    mr = {1'b0, m} + {24'd0, sum[2] & (sum[1] | sum[0] | m[0])};
    if (mr[24]) begin
      mr = mr >> 1; e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  state_t                           state_q, state_d;
  logic [PW-1:0]                    pix_q, pix_d;
  logic [KW-1:0]                    k_q, k_d;
  logic [CW-1:0]                    c_q, c_d;
  logic [DW-1:0]                    acc_q, acc_d;
  logic [C_IN-1:0][DW-1:0]          x_q, x_d;
  logic [K-1:0][DW-1:0]             fmap_q, fmap_d;
  logic [K-1:0][DW-1:0]             z_q, z_d;
  logic [K-1:0][DW-1:0]             y_q, y_d;
`ifdef PA_BP_EN
  logic [K-1:0][DW-1:0]             err_q, err_d;
  logic [DW-1:0]                    e_q, e_d;
  logic [K-1:0][DW-1:0]             eo_q, eo_d;
  logic [K-1:0][C_IN-1:0][DW-1:0]   dw_q, dw_d;
  logic [K-1:0][DW-1:0]             db_q, db_d;
`endif

  logic [K-1:0][C_IN-1:0][DW-1:0]   w_p;
  logic [K-1:0][DW-1:0]             b_p;
  logic [DW-1:0]                    mul_a, mul_b, mul_res;
  logic [DW-1:0]                    add_a, add_b, add_res;
  logic                             c_last, next_kernel;

  assign w_p    = bus.weights;
  assign b_p    = bus.biases;
  assign c_last = (c_q == CW'(C_IN - 1));

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MAC:  begin mul_a = w_p[k_q][c_q]; mul_b = x_q[c_q]; end
`ifdef PA_BP_EN
      // ReLU derivative comes from the sign bit alone, so -0.0 counts as inactive
      S_ERR:  begin mul_a = y_q[k_q][DW-1] ? '0 : FP_ONE; mul_b = err_q[k_q]; end
      S_GRAD: begin mul_a = e_q; mul_b = x_q[c_q]; end
`endif
      default: ;
    endcase
  end

  assign mul_res = fp_mul(mul_a, mul_b);

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      S_MAC:  begin add_a = acc_q; add_b = mul_res; end
      S_BIAS: begin add_a = acc_q; add_b = b_p[k_q]; end
      S_RES:  begin add_a = acc_q; add_b = fmap_q[k_q]; end
`ifdef PA_BP_EN
      S_ERR:  begin add_a = db_q[k_q]; add_b = mul_res; end
      S_GRAD: begin add_a = dw_q[k_q][c_q]; add_b = mul_res; end
`endif
      default: ;
    endcase
  end

  assign add_res = fp_add(add_a, add_b);

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    k_d         = k_q;
    c_d         = c_q;
    acc_d       = acc_q;
    x_d         = x_q;
    fmap_d      = fmap_q;
    z_d         = z_q;
    y_d         = y_q;
    next_kernel = 1'b0;
`ifdef PA_BP_EN
    err_d       = err_q;
    e_d         = e_q;
    eo_d        = eo_q;
    dw_d        = dw_q;
    db_d        = db_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef PA_BP_EN
          dw_d = '0;
          db_d = '0;
`endif
          pix_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.in_valid) begin
          x_d    = bus.x_in;
          fmap_d = bus.fmap_in;
`ifdef PA_BP_EN
          err_d  = bus.err_in;
`endif
          k_d     = '0;
          c_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = add_res;
        if (c_last) begin
          c_d     = '0;
          state_d = S_BIAS;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_BIAS: begin
        acc_d      = add_res;
        z_d[k_q]   = add_res;
        state_d    = S_RES;
      end
      S_RES: begin
        y_d[k_q] = add_res;
`ifdef PA_BP_EN
        state_d  = S_ERR;
`else
        next_kernel = 1'b1;
`endif
      end
`ifdef PA_BP_EN
      S_ERR: begin
        e_d       = mul_res;
        eo_d[k_q] = mul_res;
        db_d[k_q] = add_res;
        c_d       = '0;
        state_d   = S_GRAD;
      end
      S_GRAD: begin
        dw_d[k_q][c_q] = add_res;
        if (c_last) next_kernel = 1'b1;
        else c_d = c_q + 1'b1;
      end
`endif
      S_OUT: begin
        if (bus.out_ready) begin
          if (pix_q == PW'(NUM_PIX - 1)) begin
            state_d = S_DONE;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (next_kernel) begin
      if (k_q == KW'(K - 1)) begin
        state_d = S_OUT;
      end else begin
        k_d     = k_q + 1'b1;
        c_d     = '0;
        acc_d   = '0;
        state_d = S_MAC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      k_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      fmap_q  <= '0;
      z_q     <= '0;
      y_q     <= '0;
`ifdef PA_BP_EN
      err_q   <= '0;
      e_q     <= '0;
      eo_q    <= '0;
      dw_q    <= '0;
      db_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      k_q     <= k_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      fmap_q  <= fmap_d;
      z_q     <= z_d;
      y_q     <= y_d;
`ifdef PA_BP_EN
      err_q   <= err_d;
      e_q     <= e_d;
      eo_q    <= eo_d;
      dw_q    <= dw_d;
      db_q    <= db_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_WAIT);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.z_out     = z_q;
  assign bus.y_out     = y_q;
`ifdef PA_BP_EN
  assign bus.err_out   = eo_q;
  assign bus.dw_out    = dw_q;
  assign bus.db_out    = db_q;
`else
  assign bus.err_out   = '0;
  assign bus.dw_out    = '0;
  assign bus.db_out    = '0;
  logic unused_err_in;
  assign unused_err_in = ^bus.err_in;
`endif

endmodule

// File: tb/tb_pa_stream_adapter.sv
// Randomized bench for pa_stream_adapter against a real-arithmetic reference model.
// Operands are quarter-integers so every FP result is exact and directly comparable.
module tb_pa_stream_adapter;
  localparam int unsigned C_IN    = 3;
  localparam int unsigned K       = 2;
  localparam int unsigned NUM_PIX = 4;
`ifdef PA_BP_EN
  localparam int unsigned LAT      = K * (2 * C_IN + 3);
  localparam int unsigned ABORT_AT = C_IN + 3;
`else
  localparam int unsigned LAT      = K * (C_IN + 2);
  localparam int unsigned ABORT_AT = C_IN + 1;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  pa_stream_adapter_if #(.C_IN(C_IN), .K(K), .DW(32)) bus ();

  pa_stream_adapter #(.C_IN(C_IN), .K(K), .NUM_PIX(NUM_PIX), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  real wr [K][C_IN];
  real br [K];
  real xr [C_IN];
  real fr [K];
  real er [K];
  real dwm[K][C_IN];
  real dbm[K];
  logic [K-1:0][C_IN-1:0][31:0] wp, dw_e;
  logic [K-1:0][31:0]           bp, fmp, ep, z_e, y_e, e_e, db_e;
  logic [C_IN-1:0][31:0]        xp;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] r2f(input real v);
    real  a;
    int   e;
    logic s;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, e[7:0], 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  function automatic real rnd_q();
    int v;
    v = int'($urandom_range(32)) - 16;
    return real'(v) / 4.0;
  endfunction

  task automatic start_pass();
    for (int k = 0; k < K; k++) begin
      for (int c = 0; c < C_IN; c++) begin
        wr[k][c] = rnd_q(); wp[k][c] = r2f(wr[k][c]); dwm[k][c] = 0.0;
      end
      br[k] = rnd_q(); bp[k] = r2f(br[k]); dbm[k] = 0.0;
    end
    bus.weights = wp;
    bus.biases  = bp;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_in_ready", bus.in_ready, 1);
  endtask

  task automatic do_pixel(input int p, input int hold, input bit poke_start);
    int  n;
    real z, y, e;
    for (int c = 0; c < C_IN; c++) begin xr[c] = rnd_q(); xp[c] = r2f(xr[c]); end
    for (int k = 0; k < K; k++) begin
      fr[k] = rnd_q(); fmp[k] = r2f(fr[k]);
      er[k] = rnd_q(); ep[k]  = r2f(er[k]);
    end
    bus.x_in = xp; bus.fmap_in = fmp; bus.err_in = ep;
    bus.in_valid = 1'b1;
    for (int k = 0; k < K; k++) begin
      z = br[k];
      for (int c = 0; c < C_IN; c++) z += wr[k][c] * xr[c];
      y = z + fr[k];
      z_e[k] = r2f(z);
      y_e[k] = r2f(y);
`ifdef PA_BP_EN
      e      = (y < 0.0) ? 0.0 : er[k];
      e_e[k] = (y < 0.0) ? {ep[k][31], 31'd0} : ep[k];
      dbm[k] += e;
      for (int c = 0; c < C_IN; c++) dwm[k][c] += e * xr[c];
`else
      e      = 0.0;
      e_e[k] = '0;
`endif
    end
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.start    = poke_start;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; bus.start = 1'b0; n++; end
    bus.start = 1'b0;
    check("latency", n, LAT);
    check("in_ready_in_out", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_z", bus.z_out, z_e);
      check("hold_y", bus.y_out, y_e);
    end
    check("z_out", bus.z_out, z_e);
    check("y_out", bus.y_out, y_e);
    check("err_out", bus.err_out, e_e);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("done_after_hs", bus.done, (p == NUM_PIX - 1));
    if (p != NUM_PIX - 1) check("next_in_ready", bus.in_ready, 1);
  endtask

  task automatic end_pass(input int d0);
    @(posedge clk); #1;
    check("done_count", done_cnt - d0, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    for (int k = 0; k < K; k++) begin
`ifdef PA_BP_EN
      db_e[k] = r2f(dbm[k]);
      for (int c = 0; c < C_IN; c++) dw_e[k][c] = r2f(dwm[k][c]);
`else
      db_e[k] = '0;
      for (int c = 0; c < C_IN; c++) dw_e[k][c] = '0;
`endif
    end
    check("dw_out", bus.dw_out, dw_e);
    check("db_out", bus.db_out, db_e);
  endtask

  task automatic run_pass(input int hold_pix);
    int d0;
    start_pass();
    d0 = done_cnt;
    for (int p = 0; p < NUM_PIX; p++)
      do_pixel(p, (p == hold_pix) ? 20 : int'($urandom_range(3)), (p == 1));
    end_pass(d0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_z"}, bus.z_out, 0);
    check({tag, "_y"}, bus.y_out, 0);
    check({tag, "_err"}, bus.err_out, 0);
    check({tag, "_dw"}, bus.dw_out, 0);
    check({tag, "_db"}, bus.db_out, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start = 1'b0; bus.weights = '0; bus.biases = '0; bus.in_valid = 1'b0;
    bus.x_in = '0; bus.fmap_in = '0; bus.err_in = '0; bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_busy", bus.busy, 0);

    run_pass(-1);
    run_pass(0);

    start_pass();
    d0 = done_cnt;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (ABORT_AT) @(posedge clk);
    #1;
    check("pre_abort_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", bus.busy, 0);

    run_pass(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pa_stream_adapter.md
Name: pa_stream_adapter

Overview:
- Parametrised successor to the single-kernel parallel adapter. Implements a 1x1 convolutional parallel adapter with C_IN input channels and K kernels over a pixel stream, using 32-bit IEEE floats.
- Computes per pixel: z[k] = sum_c w[k][c]*x[c] + b[k], y[k] = z[k] + fmap[k], ReLU derivative, err_out[k].
- Accumulates weight and bias gradients across NUM_PIX pixels.
- One shared FP multiply and one FP add (the team's combinational FP wrappers) are time-multiplexed by an FSM. Valid/ready handshakes on input and output.

Parameters:
- C_IN, 6, input channels per pixel
- K, 2, adapter kernels (output channels)
- NUM_PIX, 784, pixels per pass (28*28)
- DW, 32, data width; fixed IEEE-754 single, not to be changed

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin pass; clears gradients
- weights  in  K*C_IN*DW  w[k][c] at index k*C_IN+c; sampled live, must be stable while busy
- biases  in  K*DW  b[k]; stable while busy
- in_valid  in  1  pixel bundle valid
- in_ready  out  1  block accepts pixel
- x_in  in  C_IN*DW  adapter input activations
- fmap_in  in  K*DW  main-conv feature map for this pixel
- err_in  in  K*DW  error from actv(conv+adapt)
- out_valid  out  1  per-pixel results valid
- out_ready  in  1  downstream accepts
- z_out  out  K*DW  adapter pre-sum output incl. bias
- y_out  out  K*DW  conv+adapter sum
- err_out  out  K*DW  relu'(y)*err_in
- dw_out  out  K*C_IN*DW  accumulated weight gradients
- db_out  out  K*DW  accumulated bias gradients
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, every output register goes to 0 (z_out, y_out, err_out, dw_out, db_out, out_valid, done, busy, in_ready), the FSM goes to S_IDLE, and the counters (pix, k, c) go to 0. Reset mid-pass aborts the pass with no partial done.
- States: S_IDLE, S_WAIT, S_MAC, S_BIAS, S_RES, S_ERR, S_GRAD, S_OUT, S_DONE.
- S_IDLE:
  - start=1 clears dw/db to +0.0, pix=0, then goes to S_WAIT.
  - start in any other state is ignored.
- S_WAIT:
  - in_ready=1.
  - On in_valid&in_ready, latch x_in/fmap_in/err_in into internal regs, k=0, c=0, acc=+0.0, then go to S_MAC.
- S_MAC: acc <= acc + w[k][c]*x[c]; c increments. After c=C_IN-1, go to S_BIAS.
- S_BIAS: z_out[k] <= acc + b[k]; acc <= acc + b[k].
- S_RES: y_out[k] <= acc + fmap[k].
- S_ERR:
  - deriv = y_out[k][31] ? 0.0 : 1.0, so -0.0 gives 0 and +0.0 gives 1.
  - e = deriv*err[k]; err_out[k] <= e; db[k] <= db[k] + e; c=0.
- S_GRAD: dw[k][c] <= dw[k][c] + e*x[c]; c increments. After c=C_IN-1:
  - if k<K-1: k++, acc=+0.0, c=0, go to S_MAC;
  - otherwise go to S_OUT.
- Per kernel: 2*C_IN+3 cycles. Input accept to out_valid: K*(2*C_IN+3) cycles.
- S_OUT:
  - out_valid=1; z/y/err_out held stable until out_ready.
  - On handshake: if pix==NUM_PIX-1, go to S_DONE; otherwise pix++ and go to S_WAIT.
  - Backpressure stalls indefinitely with no state loss.
- S_DONE: done=1 for one cycle, then S_IDLE. dw_out/db_out hold final values until the next start.
- busy=1 in every state except S_IDLE.
- in_ready=0 outside S_WAIT; input held by upstream.
- NaN/Inf: passed through the FP cores unmodified; no special handling.
- Rounding: round-to-nearest-even in all FP ops.

Optional Feature:
- Macro PA_BP_EN.
- Defined: full behaviour above.
- Undefined (forward-only inference):
  - S_ERR and S_GRAD are removed; S_RES goes directly to the next kernel or S_OUT.
  - err_out, dw_out and db_out are tied to 0.
  - Latency is K*(C_IN+2).
  - err_in is ignored.

Test Plan:
- C_IN=2, K=1, NUM_PIX=1. w={3F800000,40000000}, b=3F000000, x={3F800000,3F800000}, fmap=3F000000, err=3F800000 -> z_out=40600000, y_out=40800000, err_out=3F800000, db=3F800000, dw={3F800000,3F800000}, out_valid 7 cycles after accept, done once.
- Same but fmap=C0800000 -> y_out=BF000000, err_out=00000000, db=00000000, dw all 00000000.
- NUM_PIX=2, vectors of test 1 twice -> db=40000000, dw={40000000,40000000}; done only after second output handshake.
- Hold out_ready=0 for 20 cycles in S_OUT -> out_valid and outputs stable, in_ready=0; release -> single handshake, next pixel accepted.
- Assert rst mid-S_GRAD -> all outputs 0, FSM S_IDLE, no done. New start with test-1 vectors -> test-1 results.
- start pulsed while busy is ignored, results unchanged. PA_BP_EN undefined -> err_out/dw/db=0, out_valid 4 cycles after accept (C_IN=2, K=1).
